// File: rtl/pc_pkg.sv
// pc_pkg: opcodes shared by the program counter and anything that drives it.
//   pc_op_t : 2-bit opcode, INC / JMP / CALL / RET.
package pc_pkg;

  typedef enum logic [1:0] {
    OP_INC  = 2'b00,
    OP_JMP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } pc_op_t;

endpackage

// File: rtl/lifo_stack.sv
// lifo_stack: register-file return stack with an occupancy pointer.
//   clk, reset   : rising-edge clock, async active-high reset (clears occupancy)
//   push, din    : write din on top; ignored when full
//   pop          : discard the top entry; ignored when empty
//   dout         : current top entry (combinational, don't-care when empty)
//   depth        : occupied entries, 0..DEPTH
//   full, empty  : decoded from depth
module lifo_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic [DW-1:0]    top_cnt;
  logic [AW-1:0]    top_idx, wr_idx;
  logic             do_push, do_pop;

  assign full    = (depth_q == FULL_CNT);
  assign empty   = (depth_q == '0);
  assign depth   = depth_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign top_cnt = depth_q - 1'b1;
  assign top_idx = AW'(top_cnt);
  assign dout    = mem_q[top_idx];

  // A simultaneous push and pop replaces the top entry in place.
  assign wr_idx = do_pop ? top_idx : AW'(depth_q);

  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (do_push) mem_d[wr_idx] = din;
    if (do_push && !do_pop) depth_d = depth_q + 1'b1;
    else if (do_pop && !do_push) depth_d = depth_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) depth_q <= '0;
    else       depth_q <= depth_d;
  end

  // Contents need no reset: depth alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/program_counter.sv
// program_counter: PC with hardware return-address stack and sticky errors.
//   clk, reset : rising-edge clock, async active-high reset
//   enable     : 0 holds count, stack and flags (err_clr still acts)
//   op         : INC / JMP / CALL / RET (pc_op_t encoding)
//   target     : JMP / CALL destination
//   err_clr    : clears ovf and unf; a same-cycle new error still sets
//   count      : registered program counter
//   depth      : occupied stack entries; empty/full decoded from it
//   ovf, unf   : sticky CALL-on-full / RET-on-empty flags
module program_counter
  import pc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [1:0]                 op,
  input  logic [WIDTH-1:0]           target,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           count,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf
);

  pc_op_t           op_e;
  logic [WIDTH-1:0] count_q, count_d, count_inc, stk_dout;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             is_call, is_ret, stk_full, stk_empty;

  assign op_e      = pc_op_t'(op);
  assign is_call   = enable && (op_e == OP_CALL);
  assign is_ret    = enable && (op_e == OP_RET);
  assign count_inc = count_q + 1'b1;

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (is_call & ~stk_full),
    .pop   (is_ret & ~stk_empty),
    .din   (count_inc),
    .dout  (stk_dout),
    .depth (depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    count_d = count_q;
    if (enable) begin
      unique case (op_e)
        OP_INC:  count_d = count_inc;
        OP_JMP:  count_d = target;
        OP_CALL: if (!stk_full)  count_d = target;
        OP_RET:  if (!stk_empty) count_d = stk_dout;
        default: count_d = count_q;
      endcase
    end
  end

  // Set beats clear, so an error in the clearing cycle is never lost.
  assign ovf_d = (is_call & stk_full)  | (ovf_q & ~err_clr);
  assign unf_d = (is_ret  & stk_empty) | (unf_q & ~err_clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count = count_q;
  assign empty = stk_empty;
  assign full  = stk_full;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter (WIDTH=8, DEPTH=4): scenario tasks push the
// expected post-edge state to a scoreboard queue as each op is driven and
// pop/compare it once the edge has produced the DUT output.
module tb_program_counter;
  import pc_pkg::*;

  logic       clk, reset, enable, err_clr;
  logic [1:0] op;
  logic [7:0] target, count;
  logic [2:0] depth;
  logic       empty, full, ovf, unf;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic [1:0] op;
    logic [7:0] tgt;
    logic       clr;
    logic [7:0] ec;
    logic [2:0] ed;
    logic       eo;
    logic       eu;
  } step_t;

  typedef struct {
    logic [7:0] ec;
    logic [2:0] ed;
    logic       eo;
    logic       eu;
  } exp_t;

  exp_t exp_q[$];

  program_counter #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .op(op), .target(target),
    .err_clr(err_clr), .count(count), .depth(depth), .empty(empty),
    .full(full), .ovf(ovf), .unf(unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Apply one op, record what should appear after the edge, then wait past it.
  task automatic drive(input step_t s);
    enable = s.en; op = s.op; target = s.tgt; err_clr = s.clr;
    exp_q.push_back('{s.ec, s.ed, s.eo, s.eu});
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; op = OP_INC; target = '0; err_clr = 1'b0;
    #12;
    checks++;
    if (count !== 8'h00 || depth !== 3'd0 || empty !== 1'b1 || full !== 1'b0 ||
        ovf !== 1'b0 || unf !== 1'b0) begin
      failures++;
      $display("FAIL reset: count=%0h depth=%0d empty=%0b full=%0b ovf=%0b unf=%0b, want 0 0 1 0 0 0",
               count, depth, empty, full, ovf, unf);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_inc_wrap();
    exp_t e;
    for (int k = 1; k <= 260; k++) begin
      drive('{1'b1, OP_INC, 8'h00, 1'b0, 8'(k), 3'd0, 1'b0, 1'b0});
      e = exp_q.pop_front();
      checks++;
      if (count !== e.ec || depth !== e.ed || empty !== 1'b1 || ovf !== e.eo || unf !== e.eu) begin
        failures++;
        $display("FAIL inc_wrap[%0d]: count=%0h depth=%0d empty=%0b, want count=%0h depth=%0d empty=1",
                 k, count, depth, empty, e.ec, e.ed);
      end
    end
  endtask

  task automatic test_jmp_call_ret();
    step_t s[$];
    exp_t e;
    s.push_back('{1'b1, OP_JMP,  8'h40, 1'b0, 8'h40, 3'd0, 1'b0, 1'b0});
    s.push_back('{1'b1, OP_CALL, 8'h80, 1'b0, 8'h80, 3'd1, 1'b0, 1'b0});
    s.push_back('{1'b1, OP_RET,  8'h00, 1'b0, 8'h41, 3'd0, 1'b0, 1'b0});
    foreach (s[i]) begin
      drive(s[i]);
      e = exp_q.pop_front();
      checks++;
      if (count !== e.ec || depth !== e.ed || empty !== (e.ed == 0) ||
          full !== (e.ed == 4) || ovf !== e.eo || unf !== e.eu) begin
        failures++;
        $display("FAIL jmp_call_ret[%0d]: count=%0h depth=%0d ovf=%0b unf=%0b, want count=%0h depth=%0d ovf=%0b unf=%0b",
                 i, count, depth, ovf, unf, e.ec, e.ed, e.eo, e.eu);
      end
    end
  endtask

  task automatic test_overflow();
    step_t s[$];
    exp_t e;
    s.push_back('{1'b1, OP_JMP,  8'h10, 1'b0, 8'h10, 3'd0, 1'b0, 1'b0});
    s.push_back('{1'b1, OP_CALL, 8'h20, 1'b0, 8'h20, 3'd1, 1'b0, 1'b0});
    s.push_back('{1'b1, OP_CALL, 8'h30, 1'b0, 8'h30, 3'd2, 1'b0, 1'b0});
    s.push_back('{1'b1, OP_CALL, 8'h40, 1'b0, 8'h40, 3'd3, 1'b0, 1'b0});
    s.push_back('{1'b1, OP_CALL, 8'h50, 1'b0, 8'h50, 3'd4, 1'b0, 1'b0});
    s.push_back('{1'b1, OP_CALL, 8'h60, 1'b0, 8'h50, 3'd4, 1'b1, 1'b0});
    s.push_back('{1'b1, OP_RET,  8'h00, 1'b0, 8'h41, 3'd3, 1'b1, 1'b0});
    s.push_back('{1'b1, OP_RET,  8'h00, 1'b0, 8'h31, 3'd2, 1'b1, 1'b0});
    s.push_back('{1'b1, OP_RET,  8'h00, 1'b0, 8'h21, 3'd1, 1'b1, 1'b0});
    s.push_back('{1'b1, OP_RET,  8'h00, 1'b0, 8'h11, 3'd0, 1'b1, 1'b0});
    // Empty RET during a clear: unf sets, ovf clears.
    s.push_back('{1'b1, OP_RET,  8'h00, 1'b1, 8'h11, 3'd0, 1'b0, 1'b1});
    // Clear while disabled still takes effect.
    s.push_back('{1'b0, OP_INC,  8'h00, 1'b1, 8'h11, 3'd0, 1'b0, 1'b0});
    foreach (s[i]) begin
      drive(s[i]);
      e = exp_q.pop_front();
      checks++;
      if (count !== e.ec || depth !== e.ed || empty !== (e.ed == 0) ||
          full !== (e.ed == 4) || ovf !== e.eo || unf !== e.eu) begin
        failures++;
        $display("FAIL overflow[%0d]: count=%0h depth=%0d full=%0b ovf=%0b unf=%0b, want count=%0h depth=%0d ovf=%0b unf=%0b",
                 i, count, depth, full, ovf, unf, e.ec, e.ed, e.eo, e.eu);
      end
    end
  endtask

  task automatic test_underflow();
    step_t s[$];
    exp_t e;
    s.push_back('{1'b1, OP_JMP, 8'h07, 1'b0, 8'h07, 3'd0, 1'b0, 1'b0});
    s.push_back('{1'b1, OP_RET, 8'h00, 1'b0, 8'h07, 3'd0, 1'b0, 1'b1});
    s.push_back('{1'b1, OP_RET, 8'h00, 1'b1, 8'h07, 3'd0, 1'b0, 1'b1});
    s.push_back('{1'b0, OP_INC, 8'h00, 1'b1, 8'h07, 3'd0, 1'b0, 1'b0});
    foreach (s[i]) begin
      drive(s[i]);
      e = exp_q.pop_front();
      checks++;
      if (count !== e.ec || depth !== e.ed || empty !== (e.ed == 0) ||
          ovf !== e.eo || unf !== e.eu) begin
        failures++;
        $display("FAIL underflow[%0d]: count=%0h depth=%0d ovf=%0b unf=%0b, want count=%0h depth=%0d ovf=%0b unf=%0b",
                 i, count, depth, ovf, unf, e.ec, e.ed, e.eo, e.eu);
      end
    end
  endtask

  task automatic test_enable_hold();
    step_t s[$];
    exp_t e;
    s.push_back('{1'b1, OP_JMP,  8'h22, 1'b0, 8'h22, 3'd0, 1'b0, 1'b0});
    s.push_back('{1'b1, OP_CALL, 8'h90, 1'b0, 8'h90, 3'd1, 1'b0, 1'b0});
    for (int k = 0; k < 3; k++)
      s.push_back('{1'b0, OP_CALL, 8'h55, 1'b0, 8'h90, 3'd1, 1'b0, 1'b0});
    s.push_back('{1'b1, OP_RET,  8'h00, 1'b0, 8'h23, 3'd0, 1'b0, 1'b0});
    foreach (s[i]) begin
      drive(s[i]);
      e = exp_q.pop_front();
      checks++;
      if (count !== e.ec || depth !== e.ed || empty !== (e.ed == 0) ||
          ovf !== e.eo || unf !== e.eu) begin
        failures++;
        $display("FAIL enable_hold[%0d]: count=%0h depth=%0d ovf=%0b unf=%0b, want count=%0h depth=%0d ovf=%0b unf=%0b",
                 i, count, depth, ovf, unf, e.ec, e.ed, e.eo, e.eu);
      end
    end
  endtask

  task automatic test_async_reset();
    step_t s[$];
    exp_t e;
    s.push_back('{1'b1, OP_JMP,  8'h10, 1'b0, 8'h10, 3'd0, 1'b0, 1'b0});
    s.push_back('{1'b1, OP_CALL, 8'h20, 1'b0, 8'h20, 3'd1, 1'b0, 1'b0});
    s.push_back('{1'b1, OP_CALL, 8'h33, 1'b0, 8'h33, 3'd2, 1'b0, 1'b0});
    foreach (s[i]) begin
      drive(s[i]);
      e = exp_q.pop_front();
      checks++;
      if (count !== e.ec || depth !== e.ed || empty !== (e.ed == 0)) begin
        failures++;
        $display("FAIL async_setup[%0d]: count=%0h depth=%0d, want count=%0h depth=%0d",
                 i, count, depth, e.ec, e.ed);
      end
    end
    // Mid-cycle reset: outputs must clear well before the next edge.
    enable = 1'b0;
    #2 reset = 1'b1;
    exp_q.push_back('{8'h00, 3'd0, 1'b0, 1'b0});
    #1;
    e = exp_q.pop_front();
    checks++;
    if (count !== e.ec || depth !== e.ed || empty !== 1'b1 || full !== 1'b0 ||
        ovf !== e.eo || unf !== e.eu) begin
      failures++;
      $display("FAIL async_reset: count=%0h depth=%0d empty=%0b full=%0b ovf=%0b unf=%0b, want 0 0 1 0 0 0",
               count, depth, empty, full, ovf, unf);
    end
    @(negedge clk);
    reset = 1'b0;
    // First edge after release runs from count 0.
    drive('{1'b1, OP_INC, 8'h00, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0});
    e = exp_q.pop_front();
    checks++;
    if (count !== e.ec || depth !== e.ed || empty !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_inc: count=%0h depth=%0d, want count=%0h depth=%0d",
               count, depth, e.ec, e.ed);
    end
  endtask

  initial begin
    test_reset();
    test_inc_wrap();
    test_jmp_call_ret();
    test_overflow();
    test_underflow();
    test_enable_hold();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
